// File: rtl/pwm_pkg.sv
// ----------------------------------------------------------------------------
// pwm_pkg
// Shared types and default widths for the PWM channel family.
//   dt_state_e : dead-time FSM states (off, low-side on, dead-time before high,
//                high-side on, dead-time before low)
//   CNT_DW_DEF : default phase counter / duty / phase-delay width
//   DT_DW_DEF  : default dead-time counter width
// ----------------------------------------------------------------------------
package pwm_pkg;

    localparam int unsigned CNT_DW_DEF = 16;
    localparam int unsigned DT_DW_DEF  = 8;

    typedef enum logic [2:0] {
        OFF  = 3'd0,
        LO   = 3'd1,
        DT_H = 3'd2,
        HI   = 3'd3,
        DT_L = 3'd4
    } dt_state_e;

endpackage : pwm_pkg

// File: rtl/pwm_deadtime.sv
// ----------------------------------------------------------------------------
// pwm_deadtime
// Turns the raw compare result into a registered complementary drive state
// with a programmable both-off interval on every transition.
//   clk_i        clock
//   rst_ni       async reset, active low
//   raw_i        raw compare result (already gated by channel enable)
//   en_i         registered channel enable
//   fault_i      combined fault (live input or latched status)
//   dead_time_i  both-off interval in clocks, sampled on dead-time entry
//   state_o      registered FSM state
// ----------------------------------------------------------------------------
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int unsigned DtDw = DT_DW_DEF
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            raw_i,
    input  logic            en_i,
    input  logic            fault_i,
    input  logic [DtDw-1:0] dead_time_i,
    output dt_state_e       state_o
);

    dt_state_e       state_q, state_d;
    logic [DtDw-1:0] cnt_q, cnt_d;

    // State and dead-time counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; disable/fault override every state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!en_i || fault_i) begin
            state_d = OFF;
        end else begin
            unique case (state_q)
                OFF: begin
                    state_d = LO;
                end
                LO: begin
                    if (raw_i) begin
                        if (dead_time_i == '0) begin
                            state_d = HI;
                        end else begin
                            state_d = DT_H;
                            cnt_d   = dead_time_i - DtDw'(1);
                        end
                    end
                end
                DT_H: begin
                    // A raw pulse shorter than the dead time falls back to LO
                    // without ever asserting the high side.
                    if (!raw_i) begin
                        state_d = LO;
                    end else if (cnt_q == '0) begin
                        state_d = HI;
                    end else begin
                        cnt_d = cnt_q - DtDw'(1);
                    end
                end
                HI: begin
                    if (!raw_i) begin
                        if (dead_time_i == '0) begin
                            state_d = LO;
                        end else begin
                            state_d = DT_L;
                            cnt_d   = dead_time_i - DtDw'(1);
                        end
                    end
                end
                DT_L: begin
                    if (raw_i) begin
                        state_d = HI;
                    end else if (cnt_q == '0) begin
                        state_d = LO;
                    end else begin
                        cnt_d = cnt_q - DtDw'(1);
                    end
                end
                default: begin
                    state_d = OFF;
                end
            endcase
        end
    end

    assign state_o = state_q;

endmodule : pwm_deadtime

// File: rtl/pwm_chan_dt.sv
// ----------------------------------------------------------------------------
// pwm_chan_dt
// One half-bridge PWM channel: double-buffered phase/duty compare against the
// shared phase counter, complementary outputs with dead time, and a sticky
// fault shutdown.
//   clk_i          clock
//   rst_ni         async reset, active low
//   pwm_en_i       channel enable (taken only while raw compare is low)
//   invert_i       1: both outputs active-low
//   dc_resn_i      resolution; low CntDw-1-dc_resn_i bits of phase/duty ignored
//   phase_delay_i  requested on-phase
//   duty_cycle_i   requested duty
//   upd_req_i      pulse: capture phase/duty into pending registers
//   upd_pend_o     pending values not yet committed
//   dead_time_i    both-off interval in clocks
//   phase_ctr_i    shared phase counter
//   cycle_end_i    pulse: last count of the PWM period
//   fault_i        external fault, active high
//   fault_clr_i    pulse: clear latched fault (ignored while fault_i is high)
//   fault_o        latched fault status
//   pwm_hi_o       high-side drive
//   pwm_lo_o       low-side drive
// ----------------------------------------------------------------------------
module pwm_chan_dt
    import pwm_pkg::*;
#(
    parameter int unsigned CntDw = CNT_DW_DEF,
    parameter int unsigned DtDw  = DT_DW_DEF,
    parameter int unsigned ResnW = $clog2(CntDw)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             pwm_en_i,
    input  logic             invert_i,
    input  logic [ResnW-1:0] dc_resn_i,
    input  logic [CntDw-1:0] phase_delay_i,
    input  logic [CntDw-1:0] duty_cycle_i,
    input  logic             upd_req_i,
    output logic             upd_pend_o,
    input  logic [DtDw-1:0]  dead_time_i,
    input  logic [CntDw-1:0] phase_ctr_i,
    input  logic             cycle_end_i,
    input  logic             fault_i,
    input  logic             fault_clr_i,
    output logic             fault_o,
    output logic             pwm_hi_o,
    output logic             pwm_lo_o
);

    localparam int unsigned ShW = ResnW + 1;
    localparam logic [CntDw-1:0] AllOnes = '1;

    logic [CntDw-1:0] pend_phase_q, pend_duty_q;
    logic [CntDw-1:0] act_phase_q, act_duty_q;
    logic             upd_pend_q;
    logic             en_q;
    logic             fault_q;

    logic             commit_c;
    logic [ShW-1:0]   shamt_c;
    logic [CntDw-1:0] mask_c;
    logic [CntDw-1:0] on_c;
    logic [CntDw-1:0] off_c;
    logic [CntDw:0]   sum_c;
    logic             wrap_c;
    logic             cmp_c;
    logic             raw_c;
    logic             fault_any_c;
    dt_state_e        dt_state;

    // Commit pending settings at period end, or at once while disabled; a
    // request landing on the same edge restarts the wait for the next end.
    assign commit_c = upd_pend_q & ~upd_req_i & (cycle_end_i | ~en_q);

    // Pending (shadow) and active settings
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_phase_q <= '0;
            pend_duty_q  <= '0;
            act_phase_q  <= '0;
            act_duty_q   <= '0;
            upd_pend_q   <= 1'b0;
        end else begin
            if (upd_req_i) begin
                pend_phase_q <= phase_delay_i;
                pend_duty_q  <= duty_cycle_i;
                upd_pend_q   <= 1'b1;
            end else if (commit_c) begin
                upd_pend_q <= 1'b0;
            end
            if (commit_c) begin
                act_phase_q <= pend_phase_q;
                act_duty_q  <= pend_duty_q;
            end
        end
    end

    // Resolution-masked compare window; the carry out marks a window that
    // wraps past the end of the counter range.
    always_comb begin
        shamt_c = ShW'(dc_resn_i) + ShW'(1);
        mask_c  = AllOnes >> shamt_c;
        on_c    = act_phase_q & ~mask_c;
        sum_c   = {1'b0, on_c} + {1'b0, act_duty_q & ~mask_c};
        wrap_c  = sum_c[CntDw];
        off_c   = sum_c[CntDw-1:0];
        if (wrap_c) begin
            cmp_c = (phase_ctr_i >= on_c) | (phase_ctr_i < off_c);
        end else begin
            cmp_c = (phase_ctr_i >= on_c) & (phase_ctr_i < off_c);
        end
        raw_c = en_q & cmp_c;
    end

    // Enable changes only while the raw pulse is low, so no pulse is truncated
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q <= 1'b0;
        end else if (!raw_c) begin
            en_q <= pwm_en_i;
        end
    end

    // Sticky fault latch; a live fault beats a clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fault_q <= 1'b0;
        end else if (fault_i) begin
            fault_q <= 1'b1;
        end else if (fault_clr_i) begin
            fault_q <= 1'b0;
        end
    end

    assign fault_any_c = fault_i | fault_q;

    pwm_deadtime #(
        .DtDw (DtDw)
    ) u_deadtime (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .raw_i       (raw_c),
        .en_i        (en_q),
        .fault_i     (fault_any_c),
        .dead_time_i (dead_time_i),
        .state_o     (dt_state)
    );

    // The live fault term cuts the drives in the same cycle it appears
    assign pwm_hi_o   = ((dt_state == HI) & ~fault_i & ~fault_q) ^ invert_i;
    assign pwm_lo_o   = ((dt_state == LO) & ~fault_i & ~fault_q) ^ invert_i;
    assign upd_pend_o = upd_pend_q;
    assign fault_o    = fault_q;

endmodule : pwm_chan_dt
